// File: rtl/prbs9_checker.sv
// prbs9_checker: self-synchronising PRBS9 (x^9+x^5+1) receiver with lock FSM and error counters
//   clock       rising-edge system clock
//   i_reset     synchronous active-high reset
//   i_valid     qualifies i_bit, one received bit per asserted cycle
//   i_bit       received bit
//   o_locked    high while the checker is locked to the sequence
//   o_err_pulse one-cycle pulse per mismatch detected while locked
//   o_bits      bits checked since the most recent lock (saturating)
//   o_errors    errors seen since the most recent lock (saturating)
module prbs9_checker #(
    parameter int NB_COUNT   = 64,
    parameter int LOCK_MATCH = 32,
    parameter int WINDOW     = 64,
    parameter int LOSS_THR   = 8
) (
    input  logic                clock,
    input  logic                i_reset,
    input  logic                i_valid,
    input  logic                i_bit,
    output logic                o_locked,
    output logic                o_err_pulse,
    output logic [NB_COUNT-1:0] o_bits,
    output logic [NB_COUNT-1:0] o_errors
);
    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;
    localparam int MW = $clog2(LOCK_MATCH + 1);
    localparam int WW = $clog2(WINDOW + 1);
    localparam int EW = $clog2(LOSS_THR + 1);
    state_t          state;
    logic [8:0]      h;
    logic [3:0]      fill;
    logic [MW-1:0]   match;
    logic [WW-1:0]   win_bits;
    logic [EW-1:0]   win_errs;
    logic            p;
    logic            miss;
    logic [8:0]      h_rx;
    logic [3:0]      fill_nx;
    logic [MW-1:0]   match_nx;
    logic [WW-1:0]   wb_nx;
    logic [EW-1:0]   we_nx;
    assign p        = h[8] ^ h[4];
    assign miss     = i_bit != p;
    assign h_rx     = {h[7:0], i_bit};
    assign fill_nx  = fill == 4'd9 ? 4'd9 : fill + 4'd1;
    assign match_nx = match + MW'(1);
    assign wb_nx    = win_bits + WW'(1);
    assign we_nx    = win_errs + EW'(miss);
    always_ff @(posedge clock) begin
        o_err_pulse <= 1'b0;
        if (i_reset) begin
            state    <= SEARCH;
            h        <= '0;
            fill     <= '0;
            match    <= '0;
            win_bits <= '0;
            win_errs <= '0;
            o_bits   <= '0;
            o_errors <= '0;
            o_locked <= 1'b0;
        end else if (i_valid) begin
            case (state)
                SEARCH: begin
                    h    <= h_rx;
                    fill <= fill_nx;
                    // all-zero history is the PRBS lock-up state, never a valid seed
                    if (fill_nx == 4'd9 && h_rx != '0) begin
                        state <= VERIFY;
                        match <= '0;
                    end
                end
                VERIFY: begin
                    h <= h_rx;
                    if (miss) begin
                        state <= SEARCH;
                        match <= '0;
                        fill  <= 4'd9;
                    end else if (match_nx == MW'(LOCK_MATCH)) begin
                        state    <= LOCKED;
                        o_locked <= 1'b1;
                        win_bits <= '0;
                        win_errs <= '0;
                        o_bits   <= '0;
                        o_errors <= '0;
                    end else begin
                        match <= match_nx;
                    end
                end
                LOCKED: begin
                    // free-running reference so received errors cannot corrupt prediction
                    h      <= {h[7:0], p};
                    o_bits <= o_bits + NB_COUNT'(~&o_bits);
                    if (miss) begin
                        o_errors    <= o_errors + NB_COUNT'(~&o_errors);
                        o_err_pulse <= 1'b1;
                    end
                    if (we_nx == EW'(LOSS_THR)) begin
                        state    <= SEARCH;
                        o_locked <= 1'b0;
                        fill     <= '0;
                    end else if (wb_nx == WW'(WINDOW)) begin
                        win_bits <= '0;
                        win_errs <= '0;
                    end else begin
                        win_bits <= wb_nx;
                        win_errs <= we_nx;
                    end
                end
                default: state <= SEARCH;
            endcase
        end
    end
endmodule

// File: tb/tb_prbs9_checker.sv
// tb_prbs9_checker: table-driven and scoreboarded bench for prbs9_checker
module tb_prbs9_checker;
    logic        clk = 1'b0, rst = 1'b0, valid = 1'b0, bit_in = 1'b0;
    logic        locked, pulse, locked4, pulse4;
    logic [63:0] bits, errs;
    logic [3:0]  bits4, errs4;
    always #5 clk = ~clk;

    prbs9_checker dut (.clock(clk), .i_reset(rst), .i_valid(valid), .i_bit(bit_in),
        .o_locked(locked), .o_err_pulse(pulse), .o_bits(bits), .o_errors(errs));
    // narrow counters to exercise saturation
    prbs9_checker #(.NB_COUNT(4)) dut4 (.clock(clk), .i_reset(rst), .i_valid(valid), .i_bit(bit_in),
        .o_locked(locked4), .o_err_pulse(pulse4), .o_bits(bits4), .o_errors(errs4));

    typedef struct {logic locked, pulse; logic [63:0] bits, errs;} exp_t;
    exp_t sbq[$];
    int checks = 0, errors = 0;

    int          ms, mfill, mm, mwb, mwe;
    logic [8:0]  mh, g;
    logic [63:0] mbits, merr;

    function automatic logic next_prbs();
        logic nb;
        nb = g[8] ^ g[4];
        g  = {g[7:0], nb};
        return nb;
    endfunction

    function automatic logic [63:0] sat4(input logic [63:0] v);
        return v > 15 ? 64'd15 : v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // reference behaviour for one clock edge; pushes the expected outputs
    task automatic model(input logic r, input logic v, input logic b);
        logic p, mp;
        exp_t e;
        mp = 1'b0;
        if (r) begin
            ms = 0; mh = '0; mfill = 0; mm = 0; mwb = 0; mwe = 0; mbits = '0; merr = '0;
        end else if (v) begin
            p = mh[8] ^ mh[4];
            if (ms == 0) begin
                mh = {mh[7:0], b};
                if (mfill < 9) mfill++;
                if (mfill == 9 && mh != 0) begin ms = 1; mm = 0; end
            end else if (ms == 1) begin
                mh = {mh[7:0], b};
                if (b != p) begin ms = 0; mm = 0; mfill = 9; end
                else begin
                    mm++;
                    if (mm == 32) begin ms = 2; mbits = 0; merr = 0; mwb = 0; mwe = 0; end
                end
            end else begin
                mh = {mh[7:0], p};
                mbits++;
                mwb++;
                if (b != p) begin merr++; mwe++; mp = 1'b1; end
                if (mwe == 8) begin ms = 0; mfill = 0; end
                else if (mwb == 64) begin mwb = 0; mwe = 0; end
            end
        end
        e.locked = ms == 2;
        e.pulse  = mp;
        e.bits   = mbits;
        e.errs   = merr;
        sbq.push_back(e);
    endtask

    task automatic step(input logic r, input logic v, input logic b);
        exp_t e;
        @(negedge clk);
        rst = r; valid = v; bit_in = b;
        model(r, v, b);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk("sb_locked", locked, e.locked);
        chk("sb_pulse", pulse, e.pulse);
        chk("sb_bits", bits, e.bits);
        chk("sb_errors", errs, e.errs);
        chk("sb_bits4", bits4, sat4(e.bits));
        chk("sb_errors4", errs4, sat4(e.errs));
    endtask

    task automatic send(input logic b, input int os);
        for (int i = 1; i < os; i++) step(1'b0, 1'b0, 1'($urandom));
        step(1'b0, 1'b1, b);
    endtask

    // fresh seed, feeds clean PRBS (optionally one flipped bit) until lock; n=-1 on timeout
    task automatic run_to_lock(input int flip_at, output int n);
        n = 0;
        while (!locked && n < 200) begin
            n++;
            send(next_prbs() ^ (n == flip_at), 1);
        end
        if (!locked) n = -1;
    endtask

    task automatic do_reset();
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        g = 9'h1AA;
    endtask

    typedef struct {
        string       name;
        int          os;
        bit          zeros;
        int          n_after, n_flips, gap, lock_at;
        logic        locked_end;
        logic [63:0] bits_end, errs_end;
        int          pulses_end;
    } vec_t;
    vec_t vecs[5];

    initial begin
        int n, nf, pulses;
        logic b, fl;
        vecs[0] = '{"clean",       1, 0, 100, 0, 1,  41, 1, 100, 0, 0};
        vecs[1] = '{"one_flip",    1, 0, 100, 1, 1,  41, 1, 100, 1, 1};
        vecs[2] = '{"eight_flips", 1, 0, 46,  8, 5,  41, 0, 46,  8, 8};
        vecs[3] = '{"os4",         4, 0, 100, 0, 1,  41, 1, 100, 0, 0};
        vecs[4] = '{"zeros",       1, 1, 0,   0, 1,  -1, 0, 0,   0, 0};

        do_reset();
        chk("reset_locked", locked, 0);
        chk("reset_bits", bits, 0);

        for (int v = 0; v < 5; v++) begin
            do_reset();
            n = 0;
            while (!locked && n < 200) begin
                n++;
                send(vecs[v].zeros ? 1'b0 : next_prbs(), vecs[v].os);
            end
            chk({vecs[v].name, "_lock_at"}, locked ? n : -1, vecs[v].lock_at);
            pulses = 0;
            nf = 0;
            for (int k = 0; k < vecs[v].n_after; k++) begin
                b  = next_prbs();
                fl = nf < vecs[v].n_flips && k >= 10 && (k - 10) % vecs[v].gap == 0;
                if (fl) nf++;
                send(b ^ fl, vecs[v].os);
                if (pulse) pulses++;
            end
            chk({vecs[v].name, "_locked"}, locked, vecs[v].locked_end);
            chk({vecs[v].name, "_bits"}, bits, vecs[v].bits_end);
            chk({vecs[v].name, "_errors"}, errs, vecs[v].errs_end);
            chk({vecs[v].name, "_pulses"}, pulses, vecs[v].pulses_end);
        end

        // loss of lock then relock on clean data clears counters
        do_reset();
        run_to_lock(-1, n);
        for (int k = 0; k < 18; k++) send(next_prbs() ^ (k >= 10), 1);
        chk("loss_locked", locked, 0);
        chk("loss_errors_hold", errs, 8);
        run_to_lock(-1, n);
        chk("relock_at", n, 41);
        chk("relock_bits", bits, 0);
        chk("relock_errors", errs, 0);

        // seven errors either side of a window boundary keep lock
        do_reset();
        run_to_lock(-1, n);
        for (int k = 0; k < 80; k++) send(next_prbs() ^ ((k >= 57 && k <= 70)), 1);
        chk("window_split_locked", locked, 1);
        chk("window_split_errors", errs, 14);

        // eighth error on the last bit of a window: loss wins
        do_reset();
        run_to_lock(-1, n);
        for (int k = 0; k < 63; k++) send(next_prbs() ^ (k >= 56), 1);
        chk("edge_pre_locked", locked, 1);
        send(~next_prbs(), 1);
        chk("edge_loss_locked", locked, 0);
        chk("edge_bits", bits, 64);
        chk("edge_errors", errs, 8);

        // mismatch during VERIFY at bit 15 corrupts predictions of bits 20 and 24
        do_reset();
        run_to_lock(15, n);
        chk("verify_miss_lock_at", n, 57);

        // reset mid-lock overrides a valid bit
        do_reset();
        run_to_lock(-1, n);
        for (int k = 0; k < 500; k++) send(next_prbs(), 1);
        chk("mid_bits_500", bits, 500);
        step(1'b1, 1'b1, next_prbs());
        chk("mid_reset_locked", locked, 0);
        chk("mid_reset_bits", bits, 0);
        chk("mid_reset_errors", errs, 0);
        chk("mid_reset_pulse", pulse, 0);
        run_to_lock(-1, n);
        chk("mid_relock_at", n, 41);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/prbs9_checker.md
PRBS9_CHECKER -- requirements
Module: prbs9_checker

Interface
REQ-001 SHALL have parameter NB_COUNT, default 64: width of the bit and error counters.
REQ-002 SHALL have parameter LOCK_MATCH, default 32: consecutive correct predictions needed to declare lock.
REQ-003 SHALL have parameter WINDOW, default 64: length in checked bits of the loss-of-lock observation window.
REQ-004 SHALL have parameter LOSS_THR, default 8: errors within one WINDOW that force loss of lock.
REQ-005 SHALL have port clock, input, 1: system clock; all logic on the rising edge.
REQ-006 SHALL have port i_reset, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port i_valid, input, 1: qualifies i_bit; one received PRBS9 bit per asserted cycle.
REQ-008 SHALL have port i_bit, input, 1: received bit (sign of the sampled RC-filter output).
REQ-009 SHALL have port o_locked, output, 1: high while in LOCKED.
REQ-010 SHALL have port o_err_pulse, output, 1: one-cycle pulse for each mismatch detected in LOCKED.
REQ-011 SHALL have port o_bits, output, NB_COUNT: bits checked since the most recent lock.
REQ-012 SHALL have port o_errors, output, NB_COUNT: errors since the most recent lock.

Function
REQ-013 SHALL keep a 9-bit history h: h[0] = newest bit, h[8] = oldest; prediction p = h[8] XOR h[4] (x^9+x^5+1, b[n]=b[n-9]^b[n-5]).
REQ-014 SHALL change no state on cycles with i_valid low; o_err_pulse SHALL be 0 on those cycles.
REQ-015 SHALL implement states SEARCH, VERIFY and LOCKED; SEARCH is entered on reset.
REQ-016 SEARCH: each valid bit SHALL shift into h and increment a fill count saturating at 9; the state SHALL move to VERIFY on the valid cycle where the count reaches 9 with the updated h nonzero.
REQ-017 SEARCH: if h is all-zero after 9 or more bits, the state SHALL remain SEARCH, because all-zero is not a valid PRBS9 state.
REQ-018 VERIFY: each valid bit SHALL be compared with p and shifted into h.
REQ-019 VERIFY: each match SHALL increment a match count.
REQ-020 VERIFY: a mismatch SHALL return the state to SEARCH with the match count cleared, and the fill count set to 9 so the next valid bit can re-enter VERIFY.
REQ-021 VERIFY: the state SHALL move to LOCKED on the valid cycle producing match LOCK_MATCH.
REQ-022 On entry to LOCKED, o_bits, o_errors, the window bit count and the window error count SHALL be cleared.
REQ-023 LOCKED: h SHALL shift in p, not i_bit (free-running reference).
REQ-024 LOCKED: each valid cycle SHALL increment o_bits and the window bit count.
REQ-025 LOCKED: on i_bit != p, the block SHALL also increment o_errors and the window error count, and assert o_err_pulse on the next cycle.
REQ-026 LOCKED: when the window bit count reaches WINDOW, the window bit count and window error count SHALL both restart.
REQ-027 LOCKED: when the window error count reaches LOSS_THR, the state SHALL move to SEARCH with fill count 0, and o_bits and o_errors SHALL hold their values.
REQ-028 Simultaneous window end and reaching LOSS_THR: loss of lock SHALL take priority.
REQ-029 o_bits and o_errors SHALL saturate at all-ones and never wrap.
REQ-030 o_locked, o_bits and o_errors SHALL be registered, valid the cycle after the qualifying edge; no combinational path from input to output.

Reset
REQ-031 i_reset high at a clock edge SHALL force SEARCH, clear h, fill/match/window counts, o_bits and o_errors to 0, and set o_locked=0 and o_err_pulse=0.
REQ-032 Reset SHALL take priority over i_valid, including a reset asserted mid-lock.

Verification
REQ-033 Error-free PRBS9 (generator seed 0x1AA), i_valid every cycle -> o_locked rises after 9+32=41 valid bits; o_errors stays 0; after 100 further bits o_bits=100.
REQ-034 Locked stream with 1 bit flipped -> exactly one o_err_pulse and o_errors=1; o_locked stays 1.
REQ-035 Locked stream with 8 flips inside one 64-bit window -> o_locked falls on the 8th error; relock occurs on clean data; counters clear at relock.
REQ-036 All-zero input stream -> o_locked never rises.
REQ-037 i_valid toggled 1-of-4 cycles (OS=4) -> same lock point counted in valid bits; no counting on idle cycles.
REQ-038 i_reset pulsed while locked with o_bits=500 -> all outputs 0 the next cycle; relock after 41 valid bits.
